// File: rtl/add_subb_pipe.sv
// add_subb_pipe: pipelined two's complement adder/subtractor.
// Computes s = (+/-)a + (+/-)b over W bits. The carry chain is cut into S
// registered segments of G = W/S bits, each stage adding one segment and
// forwarding a carry value of 0..2. A single global enable shifts the whole
// pipe, so a stalled output freezes every stage.
module add_subb_pipe #(
    parameter int W = 64,
    parameter int S = 4
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         subb_a,
    input  logic         subb_b,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s,
    output logic         c,
    output logic         ovf
);

    localparam int G = W / S;

    // Pipe advances whenever the output slot is empty or being drained.
    logic en;

    // Stage inputs: index 0 comes from the ports, index k from stage k-1.
    logic [W-1:0] ax_d  [S];
    logic [W-1:0] bx_d  [S];
    logic [W-1:0] sum_d [S];
    logic [1:0]   cin_d [S];
    logic [S-1:0] v_d;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Operands are one's-complemented up front; the +1 of each negation
    // enters stage 0 as a carry-in, giving a carry-in of 0..2.
    assign ax_d[0]  = a ^ {W{subb_a}};
    assign bx_d[0]  = b ^ {W{subb_b}};
    assign sum_d[0] = '0;
    assign cin_d[0] = {1'b0, subb_a} + {1'b0, subb_b};
    assign v_d[0]   = in_valid;

    genvar gi;
    generate
        for (gi = 0; gi < S; gi++) begin : g_stage
            logic [G+1:0] seg_sum;
            logic [W-1:0] sum_next;
            logic [W-1:0] sum_r;
            logic         v_r;

            // Segment adder: two G-bit operand slices plus a 0..2 carry.
            always_comb begin
                seg_sum = {2'b00, ax_d[gi][gi*G +: G]}
                        + {2'b00, bx_d[gi][gi*G +: G]}
                        + {{G{1'b0}}, cin_d[gi]};
            end

            // Merge this segment into the partial sum built by earlier stages.
            always_comb begin
                sum_next = sum_d[gi];
                sum_next[gi*G +: G] = seg_sum[G-1:0];
            end

            // Valid shifts on every enable; data only loads with a valid word
            // so the output holds its last result across bubbles.
            always_ff @(posedge clk or posedge arst) begin
                if (arst) begin
                    v_r   <= 1'b0;
                    sum_r <= '0;
                end else if (en) begin
                    v_r <= v_d[gi];
                    if (v_d[gi]) begin
                        sum_r <= sum_next;
                    end
                end
            end

            if (gi < S - 1) begin : g_mid
                logic [W-1:0] ax_r;
                logic [W-1:0] bx_r;
                logic [1:0]   cy_r;

                // Carry the operands (and sign bits) and the segment carry forward.
                always_ff @(posedge clk or posedge arst) begin
                    if (arst) begin
                        ax_r <= '0;
                        bx_r <= '0;
                        cy_r <= '0;
                    end else if (en && v_d[gi]) begin
                        ax_r <= ax_d[gi];
                        bx_r <= bx_d[gi];
                        cy_r <= seg_sum[G+1:G];
                    end
                end

                assign ax_d[gi+1]  = ax_r;
                assign bx_d[gi+1]  = bx_r;
                assign sum_d[gi+1] = sum_r;
                assign cin_d[gi+1] = cy_r;
                assign v_d[gi+1]   = v_r;
            end else begin : g_last
                logic [1:0] top;
                logic       ovf_next;
                logic       c_r;
                logic       ovf_r;

                // Bits W+1..W of the sign-extended exact sum; overflow when
                // they disagree with the result's sign bit.
                always_comb begin
                    top      = {2{ax_d[gi][W-1]}} + {2{bx_d[gi][W-1]}} + seg_sum[G+1:G];
                    ovf_next = (top != {2{sum_next[W-1]}});
                end

                // Flag registers share the output stage's load condition.
                always_ff @(posedge clk or posedge arst) begin
                    if (arst) begin
                        c_r   <= 1'b0;
                        ovf_r <= 1'b0;
                    end else if (en && v_d[gi]) begin
                        c_r   <= (seg_sum[G+1:G] != 2'b00);
                        ovf_r <= ovf_next;
                    end
                end

                assign s         = sum_r;
                assign c         = c_r;
                assign ovf       = ovf_r;
                assign out_valid = v_r;
            end
        end
    endgenerate

endmodule

// File: tb/tb_add_subb_pipe.sv
// Bench for add_subb_pipe: fixed vectors (W=8,S=2), a stalled random stream
// and mid-flight reset (W=8,S=4), and exhaustive W=6 with S in {1,2,3,6}.
module tb_add_subb_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic arst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference: exact signed arithmetic for s/ovf, unsigned sum for c.
    function automatic logic [9:0] ref_model(int w, int av, int bv, bit sa, bit sb);
        int m, half, sxa, sxb, ex, us;
        logic ov;
        logic [7:0] sv;
        m    = (1 << w) - 1;
        half = 1 << (w - 1);
        sxa  = (av >= half) ? av - (1 << w) : av;
        sxb  = (bv >= half) ? bv - (1 << w) : bv;
        ex   = (sa ? -sxa : sxa) + (sb ? -sxb : sxb);
        us   = (sa ? (av ^ m) : av) + (sb ? (bv ^ m) : bv) + int'(sa) + int'(sb);
        ov   = (ex < -half) || (ex > half - 1);
        sv   = 8'(ex & m);
        return {(us > m), ov, sv};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- W=8, S=2 ----------------
    logic       p2_in_valid, p2_in_ready, p2_sa, p2_sb, p2_out_valid, p2_out_ready, p2_c, p2_ovf;
    logic [7:0] p2_a, p2_b, p2_s;

    add_subb_pipe #(.W(8), .S(2)) u_p2 (
        .clk(clk), .arst(arst), .in_valid(p2_in_valid), .in_ready(p2_in_ready),
        .subb_a(p2_sa), .subb_b(p2_sb), .a(p2_a), .b(p2_b),
        .out_valid(p2_out_valid), .out_ready(p2_out_ready), .s(p2_s), .c(p2_c), .ovf(p2_ovf)
    );

    // ---------------- W=8, S=4 ----------------
    logic       p4_in_valid, p4_in_ready, p4_sa, p4_sb, p4_out_valid, p4_out_ready, p4_c, p4_ovf;
    logic [7:0] p4_a, p4_b, p4_s;

    add_subb_pipe #(.W(8), .S(4)) u_p4 (
        .clk(clk), .arst(arst), .in_valid(p4_in_valid), .in_ready(p4_in_ready),
        .subb_a(p4_sa), .subb_b(p4_sb), .a(p4_a), .b(p4_b),
        .out_valid(p4_out_valid), .out_ready(p4_out_ready), .s(p4_s), .c(p4_c), .ovf(p4_ovf)
    );

    // ---------------- W=6, S in {1,2,3,6} ----------------
    localparam int NEX = 16384;
    logic       e_in_valid, e_sa, e_sb;
    logic [5:0] e_a, e_b;
    logic       e_out_ready;
    int         e_sent = 0;
    int         rec_a   [NEX];
    int         rec_b   [NEX];
    bit         rec_sa  [NEX];
    bit         rec_sb  [NEX];
    int         rec_cyc [NEX];
    int         e_got   [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ex
            localparam int SV = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 3 : 6;
            logic       o_valid, i_ready, o_c, o_ovf;
            logic [5:0] o_s;
            int         cnt = 0;

            add_subb_pipe #(.W(6), .S(SV)) u_ex (
                .clk(clk), .arst(arst), .in_valid(e_in_valid), .in_ready(i_ready),
                .subb_a(e_sa), .subb_b(e_sb), .a(e_a), .b(e_b),
                .out_valid(o_valid), .out_ready(e_out_ready), .s(o_s), .c(o_c), .ovf(o_ovf)
            );

            assign e_got[gi] = cnt;

            always @(negedge clk) begin
                logic [9:0] exp;
                if (o_valid) begin
                    if (cnt >= e_sent) begin
                        checks++;
                        errors++;
                        $display("FAIL exh_S%0d_extra actual=valid required=idle", SV);
                    end else begin
                        exp = ref_model(6, rec_a[cnt], rec_b[cnt], rec_sa[cnt], rec_sb[cnt]);
                        check($sformatf("exh_S%0d_lat_i%0d", SV, cnt), 32'(cyc - rec_cyc[cnt]), 32'(SV));
                        check($sformatf("exh_S%0d_res_i%0d", SV, cnt), {o_c, o_ovf, o_s},
                              {exp[9], exp[8], exp[5:0]});
                        cnt <= cnt + 1;
                    end
                end
            end
        end
    endgenerate

    // Fixed vectors for W=8, S=2.
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit         sa;
        bit         sb;
        logic [7:0] s;
        bit         c;
        bit         ovf;
    } vec_t;

    vec_t       tbl [6];
    logic [7:0] wa [20];
    logic [7:0] wb [20];
    bit         wsa [20];
    bit         wsb [20];
    logic [9:0] q [$];

    initial begin
        int lat, idx, got;
        logic [9:0] exp;

        tbl[0] = '{8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0};
        tbl[1] = '{8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
        tbl[2] = '{8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        tbl[3] = '{8'h80, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[4] = '{8'h64, 8'h64, 1'b0, 1'b0, 8'hC8, 1'b0, 1'b1};
        tbl[5] = '{8'h80, 8'h80, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1};

        arst = 1'b1;
        p2_in_valid = 0; p2_sa = 0; p2_sb = 0; p2_a = 0; p2_b = 0; p2_out_ready = 1;
        p4_in_valid = 0; p4_sa = 0; p4_sb = 0; p4_a = 0; p4_b = 0; p4_out_ready = 1;
        e_in_valid = 0; e_sa = 0; e_sb = 0; e_a = 0; e_b = 0; e_out_ready = 1;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(p4_out_valid), 0);
        check("rst_in_ready", 32'(p4_in_ready), 1);
        check("rst_s", 32'(p4_s), 0);
        check("rst_c_ovf", {p4_c, p4_ovf}, 0);
        check("rst_p2_out_valid", 32'(p2_out_valid), 0);
        arst = 1'b0;
        @(negedge clk);

        // Phase 1: table vectors, one word at a time, latency measured.
        for (int i = 0; i < 6; i++) begin
            p2_in_valid = 1; p2_a = tbl[i].a; p2_b = tbl[i].b; p2_sa = tbl[i].sa; p2_sb = tbl[i].sb;
            lat = 0;
            for (int n = 1; n <= 10; n++) begin
                @(negedge clk);
                p2_in_valid = 0;
                if (p2_out_valid) begin
                    lat = n;
                    break;
                end
            end
            check($sformatf("tbl%0d_latency", i), 32'(lat), 2);
            check($sformatf("tbl%0d_s", i), 32'(p2_s), 32'(tbl[i].s));
            check($sformatf("tbl%0d_c", i), 32'(p2_c), 32'(tbl[i].c));
            check($sformatf("tbl%0d_ovf", i), 32'(p2_ovf), 32'(tbl[i].ovf));
        end

        // Phase 2: random stream with a 3-cycle output stall.
        for (int i = 0; i < 20; i++) begin
            wa[i] = 8'($urandom); wb[i] = 8'($urandom);
            wsa[i] = 1'($urandom); wsb[i] = 1'($urandom);
        end
        idx = 0; got = 0;
        for (int n = 0; n < 300 && (idx < 20 || q.size() > 0); n++) begin
            @(negedge clk);
            p4_out_ready = !(n >= 9 && n < 12);
            p4_in_valid  = (idx < 20);
            if (idx < 20) begin
                p4_a = wa[idx]; p4_b = wb[idx]; p4_sa = wsa[idx]; p4_sb = wsb[idx];
            end
            #1;
            check($sformatf("stream_in_ready_n%0d", n), 32'(p4_in_ready),
                  32'(!(p4_out_valid && !p4_out_ready)));
            if (p4_out_valid && p4_out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stream_extra actual=valid required=no_result");
                end else begin
                    exp = q.pop_front();
                    check($sformatf("stream_res%0d", got), {p4_c, p4_ovf, p4_s}, 32'(exp));
                    got++;
                end
            end
            if (p4_in_valid && p4_in_ready) begin
                q.push_back(ref_model(8, int'(wa[idx]), int'(wb[idx]), wsa[idx], wsb[idx]));
                idx++;
            end else if (p4_in_valid) begin
                // Scramble operands while blocked; they must be ignored.
                p4_a = 8'($urandom); p4_b = 8'($urandom); p4_sa = 1'($urandom);
            end
        end
        p4_in_valid = 0;
        p4_out_ready = 1;
        check("stream_count", 32'(got), 20);

        // Phase 3: asynchronous reset with two words in flight.
        @(negedge clk);
        p4_in_valid = 1; p4_a = 8'h7F; p4_b = 8'h01; p4_sa = 0; p4_sb = 0;
        @(negedge clk);
        p4_a = 8'h80; p4_b = 8'h80; p4_sa = 1; p4_sb = 0;
        @(negedge clk);
        p4_in_valid = 0;
        #1 arst = 1'b1;
        #1;
        check("arst_out_valid", 32'(p4_out_valid), 0);
        check("arst_s", 32'(p4_s), 0);
        check("arst_c_ovf", {p4_c, p4_ovf}, 0);
        check("arst_in_ready", 32'(p4_in_ready), 1);
        @(negedge clk);
        arst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check($sformatf("post_rst_idle%0d", n), 32'(p4_out_valid), 0);
        end

        // Phase 4: exhaustive W=6 across four depths, back-to-back.
        for (int i = 0; i < NEX; i++) begin
            @(negedge clk);
            e_in_valid = 1;
            e_a = i[5:0]; e_b = i[11:6]; e_sa = i[12]; e_sb = i[13];
            rec_a[i] = int'(i[5:0]); rec_b[i] = int'(i[11:6]);
            rec_sa[i] = i[12]; rec_sb[i] = i[13];
            rec_cyc[i] = cyc;
            e_sent = i + 1;
        end
        @(negedge clk);
        e_in_valid = 0;
        repeat (10) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            check($sformatf("exh_count_g%0d", g), 32'(e_got[g]), 32'(NEX));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_subb_pipe.md
Name: add_subb_pipe

Overview:
- Pipelined, parametrised two's complement adder/subtractor.
- Computes s = (-1)^subb_a * a + (-1)^subb_b * b over W bits, with signed-overflow and carry flags.
- The carry chain is split into S registered segments; a valid/ready handshake carries operands through the pipe.
- Datapath building block for the BKM FPU iteration stages, where wide ripple adders limit the clock rate.

Parameters:
- W, 64: word width in bits. W >= 2, and W mod S == 0.
- S, 4: number of pipeline stages (carry segments), 1 <= S <= W. Segment width G = W/S.

Ports:
- clk, input, 1: clock, rising edge.
- arst, input, 1: asynchronous active-high reset.
- in_valid, input, 1: operand word valid.
- in_ready, output, 1: block can accept an operand word this cycle.
- subb_a, input, 1: 0 = +a, 1 = -a.
- subb_b, input, 1: 0 = +b, 1 = -b.
- a, input, W: operand a, two's complement.
- b, input, W: operand b, two's complement.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result.
- s, output, W: result, two's complement, modulo 2^W.
- c, output, 1: unsigned carry-out of bit W-1 of the full sum (a^subb_a) + (b^subb_b) + subb_a + subb_b. Both correction ones are injected at bit 0, so the carry-out can be 2; c is 1 when it is >= 1.
- ovf, output, 1: exact mathematical result lies outside [-2^(W-1), 2^(W-1)-1].

Behaviour:
- Reset: arst asserted clears all stage valid bits, stage data registers, s, c and ovf to 0, asynchronously. in_ready is 1 after reset.
- Global advance: en = !out_valid || out_ready. in_ready = en. The whole pipe shifts only when en = 1; no bubble collapsing.
- Transfer occurs when in_valid && in_ready; the stage-0 valid bit captures in_valid when en = 1.
- Latency: exactly S cycles from the accepting edge to out_valid when no stall occurs. Throughput is 1 result per cycle.
- Stage k (0..S-1) adds bits [k*G +: G] of a^subb_a and b^subb_b.
  - Incoming carry state: stage 0 takes subb_a and subb_b as two carry-ins at weight 1. Stage k>0 takes the carry value 0..2 registered by stage k-1.
  - Outgoing: a G-bit partial sum plus a carry value 0..2, registered.
  - Higher operand bits and sign info are delayed alongside in registers.
- Stall: when out_valid && !out_ready, all stage registers and outputs hold their values. in_ready = 0 and inputs are ignored.
- Output registers hold the last result while out_valid is low. The bench only checks s, c and ovf when out_valid = 1.
- ovf: computed from the sign-extended (W+2)-bit exact sum of the negated/unnegated operands. It is 1 iff bits W+1..W-1 are not all equal.
  - Covers negation of -2^(W-1) alone, i.e. subb_a = 1, a = 100..0, b = 0.
- c = 1 iff the final carry value out of stage S-1 is nonzero.
- Operands changing while in_ready = 0 have no effect.
- arst asserted mid-stream discards all in-flight words. No output with out_valid = 1 may appear for pre-reset inputs after reset is released.
- S = 1 degenerates to a single registered W-bit adder with 1-cycle latency.

Test Plan:
- W=8,S=2: a=5,b=3,subb=00 -> 2 cycles later out_valid=1, s=0x08, ovf=0.
- W=8,S=2: a=5,b=3,subb_b=1 -> s=0x02, ovf=0. a=3,b=5,subb_b=1 -> s=0xFE, ovf=0.
- W=8,S=2: a=0x80,b=0x00,subb_a=1 -> s=0x80, ovf=1. a=100,b=100,subb=00 -> s=0xC8, ovf=1. a=0x80,b=0x80,subb=11 -> s=0x00, ovf=1.
- W=8,S=4: stream 20 random words back-to-back; drop out_ready for 3 cycles mid-stream.
  - Results must match the reference model in order, with none lost or duplicated.
  - in_ready must be low exactly when out_valid && !out_ready.
- Reset mid-operation: assert arst with 2 words in flight. All valids go to 0 immediately, s=c=ovf=0, and no stale result appears after release.
- Exhaustive W=6, S in {1,2,3,6}: all a, b, subb combinations. s, c and ovf must match the model at latency S.
